// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver presenting bytes on a valid/ready stream.
// Mid-bit sampling off a CLKDIV divider, framing-error and overrun pulses.
// Optional macro UART_RX_FIFO_EN swaps the single holding register for a 4-entry FIFO.
`ifndef UART_DIV
`define UART_DIV 16
`endif

module uart_rx #(
  parameter int unsigned CLKDIV = `UART_DIV
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       srst_i,
  input  logic       uart_rx_i,
  output logic       out_val_o,
  output logic [7:0] out_data_o,
  input  logic       out_rdy_i,
  output logic       uart_cts_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned DIV_W   = $clog2(CLKDIV);
  localparam int unsigned HALF_M1 = CLKDIV / 2 - 1;
  localparam int unsigned FULL_M1 = CLKDIV - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic             r_meta;
  logic             r_rx_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_tick;
  logic w_div_clr;
  logic w_div_inc;
  logic w_shift_en;
  logic w_idx_clr;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_pop;
  logic w_push;

  // Two-flop synchronizer on the asynchronous line, idle-high after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else if (srst_i) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= uart_rx_i;
      r_rx_s <= r_meta;
    end
  end

  // Sample strobe: half a bit into the start bit, a full bit thereafter
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      S_START:        w_tick = (r_div == DIV_W'(HALF_M1));
      S_DATA, S_STOP: w_tick = (r_div == DIV_W'(FULL_M1));
      default:        w_tick = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else if (srst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: divider control, shift enable, stop-bit verdict
  always_comb begin
    w_div_clr  = 1'b0;
    w_div_inc  = 1'b0;
    w_shift_en = 1'b0;
    w_idx_clr  = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_clr = !r_rx_s;
      end
      S_START: begin
        w_div_clr = w_tick;
        w_div_inc = !w_tick;
        w_idx_clr = w_tick;
      end
      S_DATA: begin
        w_div_clr  = w_tick;
        w_div_inc  = !w_tick;
        w_shift_en = w_tick;
      end
      S_STOP: begin
        w_div_clr  = w_tick;
        w_div_inc  = !w_tick;
        w_stop_ok  = w_tick && r_rx_s;
        w_stop_bad = w_tick && !r_rx_s;
      end
      default: begin
        w_div_clr = 1'b0;
      end
    endcase
  end

  // Bit-timing divider, bit index and LSB-first shift register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (srst_i) begin
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_div_clr) begin
        r_div <= '0;
      end else if (w_div_inc) begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
      end
    end
  end

  assign w_pop = out_val_o && out_rdy_i;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH = 4;

  logic [7:0] r_mem [DEPTH];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       w_full;

  assign w_full = (r_count == 3'd4);
  // A pop in the same cycle frees the slot for the incoming byte
  assign w_push = w_stop_ok && (!w_full || w_pop);

  // Receive FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (srst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_val_o  = (r_count != 3'd0);
  assign out_data_o = r_mem[r_rptr];
  assign uart_cts_o = (r_count < 3'd3);
`else
  logic       r_full;
  logic [7:0] r_data;

  // A pop in the same cycle frees the slot for the incoming byte
  assign w_push = w_stop_ok && (!r_full || w_pop);

  // Single holding register with full flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (srst_i) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_push) begin
        r_full <= 1'b1;
        r_data <= r_shift;
      end else if (w_pop) begin
        r_full <= 1'b0;
      end
    end
  end

  assign out_val_o  = r_full;
  assign out_data_o = r_data;
  assign uart_cts_o = !r_full;
`endif

  // Registered error pulses, aligned with where out_val_o would rise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (srst_i) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_ok && !w_push;
    end
  end

  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx, checked every cycle
// against a frame-level queue model plus hand-computed literal expectations.
module tb_uart_rx;

  localparam int unsigned D = 16;
  localparam int unsigned H = D / 2;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CTS_LIM  = 3;
  localparam logic [4:0]  CTS_TBL  = 5'b00011;
  localparam logic [7:0]  SIM_HEAD = 8'hC1;
`else
  localparam int unsigned DEPTH    = 1;
  localparam int unsigned CTS_LIM  = 1;
  localparam logic [4:0]  CTS_TBL  = 5'b00000;
  localparam logic [7:0]  SIM_HEAD = 8'h5A;
`endif

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       srst_i    = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic       out_rdy_i = 1'b0;
  logic       out_val_o;
  logic [7:0] out_data_o;
  logic       uart_cts_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(.CLKDIV(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .srst_i      (srst_i),
    .uart_rx_i   (uart_rx_i),
    .out_val_o   (out_val_o),
    .out_data_o  (out_data_o),
    .out_rdy_i   (out_rdy_i),
    .uart_cts_o  (uart_cts_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned edge_n;
    logic [7:0]  b;
    bit          ok;
  } ev_t;

  ev_t         pend[$];
  logic [7:0]  mq[$];
  logic [7:0]  rx_log[$];
  bit          exp_fe;
  bit          exp_ov;
  int unsigned cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          chk_en  = 1'b0;
  int          fe_cnt  = 0;
  int          ov_cnt  = 0;
  int          rdy_mode = 0;
  bit          rdy_const = 1'b1;
  int unsigned pulse_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Frame-level model: completed frames land in a bounded queue at their stop-sample edge
  always @(posedge clk_i) begin
    ev_t e;
    bit  pop;
    bit  was_full;
    cyc    = cyc + 1;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (!rst_ni || srst_i) begin
      mq.delete();
      pend.delete();
    end else begin
      pop      = (mq.size() != 0) && out_rdy_i;
      was_full = (mq.size() >= DEPTH);
      if (pop) void'(mq.pop_front());
      if (pend.size() != 0 && pend[0].edge_n == cyc) begin
        e = pend.pop_front();
        if (!e.ok) exp_fe = 1'b1;
        else if (!was_full || pop) mq.push_back(e.b);
        else exp_ov = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, and log handshakes/pulses
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (out_val_o && out_rdy_i) rx_log.push_back(out_data_o);
      fe_cnt += int'(frame_err_o);
      ov_cnt += int'(overrun_o);
    end
    if (rst_ni && chk_en) begin
      chk("val", 32'(out_val_o), 32'(mq.size() != 0));
      chk("cts", 32'(uart_cts_o), 32'(mq.size() < CTS_LIM));
      chk("frame_err", 32'(frame_err_o), 32'(exp_fe));
      chk("overrun", 32'(overrun_o), 32'(exp_ov));
      if (mq.size() != 0) chk("data", 32'(out_data_o), 32'(mq[0]));
    end
  end

  // Consumer ready: constant, random, or a single-cycle pulse at a chosen edge
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      1:       out_rdy_i = 1'($urandom_range(0, 1));
      2:       out_rdy_i = ((cyc + 1) == pulse_edge);
      default: out_rdy_i = rdy_const;
    endcase
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive one 8N1 frame; optional soft reset mid data bit, optional low hold after stop
  task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bit,
                            input int unsigned hold);
    ev_t e;
    @(posedge clk_i);
    #1;
    e.edge_n = cyc + 3 + H + 9 * D;
    e.b      = b;
    e.ok     = stop;
    pend.push_back(e);
    uart_rx_i = 1'b0;
    wait_cyc(D);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      if (i == abort_bit) begin
        wait_cyc(H);
        srst_i = 1'b1;
        wait_cyc(1);
        srst_i = 1'b0;
        wait_cyc(D - H - 1);
      end else begin
        wait_cyc(D);
      end
    end
    uart_rx_i = stop;
    wait_cyc(D + (stop ? 0 : hold));
    uart_rx_i = 1'b1;
  endtask

  task automatic glitch(input int unsigned len);
    @(posedge clk_i);
    #1;
    uart_rx_i = 1'b0;
    wait_cyc(len);
    uart_rx_i = 1'b1;
    wait_cyc(H + 8);
  endtask

  logic [7:0] ovr_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [4:0] cts_tbl;
  int         fe0;
  int         ov0;

  initial begin
    cts_tbl = CTS_TBL;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_val", 32'(out_val_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_cts", 32'(uart_cts_o), 32'd1);
    chk("rst_fe", 32'(frame_err_o), 32'd0);
    chk("rst_ov", 32'(overrun_o), 32'd0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    wait_cyc(4);

    // Two near back-to-back good frames
    rx_log.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b1, -1, 0);
    send_frame(8'hA3, 1'b1, -1, 0);
    wait_cyc(10);
    chk("b2b_n", 32'(rx_log.size()), 32'd2);
    if (rx_log.size() == 2) begin
      chk("b2b_0", 32'(rx_log[0]), 32'h55);
      chk("b2b_1", 32'(rx_log[1]), 32'hA3);
    end
    chk("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("b2b_ov", 32'(ov_cnt - ov0), 32'd0);

    // Short low glitch on an idle line
    rx_log.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    glitch(5);
    chk("glitch_n", 32'(rx_log.size()), 32'd0);
    chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("glitch_ov", 32'(ov_cnt - ov0), 32'd0);

    // Framing error followed by a long break, then recovery
    rx_log.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, -1, 40 * D);
    wait_cyc(10);
    send_frame(8'h7E, 1'b1, -1, 0);
    wait_cyc(10);
    chk("brk_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("brk_n", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() == 1) chk("brk_data", 32'(rx_log[0]), 32'h7E);

    // Overrun with consumer stalled
    rx_log.delete(); ov0 = ov_cnt;
    rdy_const = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      send_frame(ovr_bytes[i], 1'b1, -1, 0);
      wait_cyc(4);
      chk("ovr_cts_step", 32'(uart_cts_o), 32'(cts_tbl[i]));
    end
    chk("ovr_val", 32'(out_val_o), 32'd1);
    chk("ovr_head", 32'(out_data_o), 32'h11);
    chk("ovr_ov", 32'(ov_cnt - ov0), 32'd1);
    rdy_const = 1'b1;
    wait_cyc(2 * DEPTH + 6);
    chk("ovr_drain_n", 32'(rx_log.size()), 32'(DEPTH));
    for (int i = 0; i < rx_log.size() && i < int'(DEPTH); i++)
      chk("ovr_drain", 32'(rx_log[i]), 32'(ovr_bytes[i]));

    // Soft reset in data bit 4 of 0xFF, then a clean frame
    rx_log.delete(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hFF, 1'b1, 4, 0);
    wait_cyc(10);
    send_frame(8'h81, 1'b1, -1, 0);
    wait_cyc(10);
    chk("srst_n", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() == 1) chk("srst_data", 32'(rx_log[0]), 32'h81);
    chk("srst_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

    // Byte completes on the same edge the consumer pops a full buffer
    rx_log.delete(); ov0 = ov_cnt;
    rdy_const = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < int'(DEPTH); i++) begin
      send_frame(8'(8'hC0 + i), 1'b1, -1, 0);
      wait_cyc(4);
    end
    pulse_edge = cyc + 1 + 3 + H + 9 * D;
    rdy_mode   = 2;
    send_frame(8'h5A, 1'b1, -1, 0);
    wait_cyc(4);
    chk("sim_ov", 32'(ov_cnt - ov0), 32'd0);
    chk("sim_pop_n", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() == 1) chk("sim_pop", 32'(rx_log[0]), 32'hC0);
    chk("sim_val", 32'(out_val_o), 32'd1);
    chk("sim_head", 32'(out_data_o), 32'(SIM_HEAD));
    rdy_mode  = 0;
    rdy_const = 1'b1;
    wait_cyc(2 * DEPTH + 6);
    chk("sim_drain_n", 32'(rx_log.size()), 32'(DEPTH + 1));
    if (rx_log.size() == DEPTH + 1) chk("sim_last", 32'(rx_log[DEPTH]), 32'h5A);

    // Randomized traffic with random consumer backpressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) glitch($urandom_range(1, H - 2));
      else send_frame(8'($urandom), (r > 1), -1, (r == 1) ? $urandom_range(0, 3 * D) : 0);
      wait_cyc($urandom_range(4, 40));
    end
    rdy_mode  = 0;
    rdy_const = 1'b1;
    wait_cyc(20);
    chk("end_empty", 32'(out_val_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
